// File: rtl/cybercobra_run_ctrl.sv
// cybercobra_run_ctrl
// Run/step/halt sequencer for the CYBERcobra core. It generates the core
// reset and the per-cycle execute enable, and counts executed instructions.
// Optional feature macro: CYBERCOBRA_BREAKPOINT_EN. When it is defined, a PC
// breakpoint stops the core before the instruction at bp_addr_i executes.
module cybercobra_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             restart_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic             bp_valid_i,
    output logic             core_rst_o,
    output logic             core_en_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_RELOAD = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        CORE_RST = 3'd0,
        HALTED   = 3'd1,
        RUNNING  = 3'd2,
        STEPPING = 3'd3,
        BROKEN   = 3'd4
    } run_state_t;

    run_state_t        state;
    logic [RC_W-1:0]   rst_cnt;
    logic              core_rst;
    logic [CNT_W-1:0]  instr_cnt;
    logic              bp_hit;

`ifdef CYBERCOBRA_BREAKPOINT_EN
    logic              skip;

    // A breakpoint only blocks free running; skip lets the stopped-at instruction execute once.
    always_comb begin
        bp_hit = (state == RUNNING) && bp_valid_i && (pc_i == bp_addr_i) && !skip;
    end
`else
    logic              unused_bp;

    // Breakpoint inputs are not used in this build; bp_hit is tied off.
    always_comb begin
        bp_hit    = 1'b0;
        unused_bp = ^{pc_i, bp_addr_i, bp_valid_i};
    end
`endif

    // Execute enable: the core commits an instruction in every cycle this is high.
    always_comb begin
        core_en_o = ((state == RUNNING) && !bp_hit) || (state == STEPPING);
    end

    // Sequencer FSM with core reset timer, saturating instruction counter and skip flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= CORE_RST;
            rst_cnt   <= RST_RELOAD;
            core_rst  <= 1'b1;
            instr_cnt <= '0;
`ifdef CYBERCOBRA_BREAKPOINT_EN
            skip      <= 1'b0;
`endif
        end else begin
            if (core_en_o && (instr_cnt != {CNT_W{1'b1}})) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
`ifdef CYBERCOBRA_BREAKPOINT_EN
            if (core_en_o) begin
                skip <= 1'b0;
            end
`endif
            if (state == CORE_RST) begin
                if (rst_cnt == '0) begin
                    state    <= HALTED;
                    core_rst <= 1'b0;
                end else begin
                    rst_cnt <= rst_cnt - 1'b1;
                end
            end else if (restart_i) begin
                state     <= CORE_RST;
                rst_cnt   <= RST_RELOAD;
                core_rst  <= 1'b1;
                instr_cnt <= '0;
`ifdef CYBERCOBRA_BREAKPOINT_EN
                skip      <= 1'b0;
`endif
            end else begin
                case (state)
                    HALTED: begin
                        if (halt_i) begin
                            state <= HALTED;
                        end else if (step_i) begin
                            state <= STEPPING;
                        end else if (run_i) begin
                            state <= RUNNING;
                        end
                    end
                    RUNNING: begin
                        if (halt_i) begin
                            state <= HALTED;
                        end else if (bp_hit) begin
                            state <= BROKEN;
                        end
                    end
                    STEPPING: begin
                        state <= HALTED;
                    end
`ifdef CYBERCOBRA_BREAKPOINT_EN
                    BROKEN: begin
                        if (halt_i) begin
                            state <= HALTED;
                        end else if (step_i) begin
                            state <= STEPPING;
                            skip  <= 1'b1;
                        end else if (run_i) begin
                            state <= RUNNING;
                            skip  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= HALTED;
                    end
                endcase
            end
        end
    end

    assign core_rst_o  = core_rst;
    assign state_o     = state;
    assign instr_cnt_o = instr_cnt;

endmodule
